// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the rectangle-fill engine and its raster counter.
package vga_pkg;
    localparam int H_RES   = 160;
    localparam int V_RES   = 120;
    localparam int VGA_XW  = 10;
    localparam int VGA_YW  = 9;
    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} rect_state_t;
endpackage

// File: rtl/vga_scan_counter.sv
// Raster-order 2-D counter: walks x_start..x_end per row, then bumps y.
// last flags the bottom-right corner of the current window.
module vga_scan_counter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [VGA_XW-1:0] x_start,
    input  logic [VGA_YW-1:0] y_start,
    input  logic [VGA_XW-1:0] x_end,
    input  logic [VGA_YW-1:0] y_end,
    input  logic              advance,
    output logic [VGA_XW-1:0] x,
    output logic [VGA_YW-1:0] y,
    output logic              last
);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= x_start;
            y <= y_start;
        end else if (advance) begin
            if (x == x_end) begin
                x <= x_start;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign last = (x == x_end) && (y == y_end);
endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: latches a start request, clips to the visible area and
// emits one registered plot strobe per pixel in raster order, then a done pulse.
module vga_rect_fill
    import vga_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               Resetn,
    input  logic               start,
    input  logic [VGA_XW-1:0]  x0,
    input  logic [VGA_YW-1:0]  y0,
    input  logic [VGA_XW-1:0]  w,
    input  logic [VGA_YW-1:0]  h,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic [VGA_XW-1:0]  VGA_X,
    output logic [VGA_YW-1:0]  VGA_Y,
    output logic [COLOR_W-1:0] VGA_COLOR,
    output logic               plot
);
    rect_state_t        state;
    logic [VGA_XW-1:0]  x0_q, w_q;
    logic [VGA_YW-1:0]  y0_q, h_q;
    logic [COLOR_W-1:0] color_q;
    logic               last_q;

    logic [VGA_XW:0]    x_sum;
    logic [VGA_YW:0]    y_sum;
    logic [VGA_XW-1:0]  x_end, scan_x, x_start;
    logic [VGA_YW-1:0]  y_end, scan_y, y_start;
    logic               empty, scan_last, load, advance;

    // Extra MSB keeps x0+w-1 from wrapping before the clip compare.
    assign x_sum = {1'b0, x0_q} + {1'b0, w_q} - 1'b1;
    assign y_sum = {1'b0, y0_q} + {1'b0, h_q} - 1'b1;
    assign x_end = (x_sum > (VGA_XW+1)'(H_RES - 1)) ? VGA_XW'(H_RES - 1) : x_sum[VGA_XW-1:0];
    assign y_end = (y_sum > (VGA_YW+1)'(V_RES - 1)) ? VGA_YW'(V_RES - 1) : y_sum[VGA_YW-1:0];
    assign empty = (w_q == '0) || (h_q == '0) ||
                   (x0_q >= VGA_XW'(H_RES)) || (y0_q >= VGA_YW'(V_RES));

    // The counter is loaded straight from the inputs on the start edge so the first
    // pixel is ready to register while the clip is evaluated in SETUP.
    assign load    = (state == IDLE) && start;
    assign advance = ((state == SETUP) && !empty) || ((state == DRAW) && !last_q);
    assign x_start = load ? x0 : x0_q;
    assign y_start = load ? y0 : y0_q;

    vga_scan_counter u_scan (
        .clk     (CLOCK_50),
        .resetn  (Resetn),
        .load    (load),
        .x_start (x_start),
        .y_start (y_start),
        .x_end   (x_end),
        .y_end   (y_end),
        .advance (advance),
        .x       (scan_x),
        .y       (scan_y),
        .last    (scan_last)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            plot      <= 1'b0;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            last_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x0_q    <= x0;
                        y0_q    <= y0;
                        w_q     <= w;
                        h_q     <= h;
                        color_q <= color;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP, DRAW: begin
                    // last_q marks that the pixel currently on the port was the final one.
                    if ((state == SETUP && empty) || (state == DRAW && last_q)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        plot      <= 1'b1;
                        VGA_X     <= scan_x;
                        VGA_Y     <= scan_y;
                        VGA_COLOR <= color_q;
                        last_q    <= scan_last;
                        state     <= DRAW;
                    end
                end
                DONE: begin
                    last_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
